// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: the data port has priority, the fetch
// port wins after STARVE_MAX back-to-back data grants; reads return after MEM_LAT cycles.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   localparam int CW = 3;
   localparam int SW = $clog2(STARVE_MAX + 2);

   typedef enum logic {IDLE, RD} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [SW-1:0] starve_reg, starve_next;
   logic          owner_reg, owner_next;   // 1 = data port owns the outstanding read

   logic          ret_cycle, arb_cycle, fetch_first;
   logic          gnt_if, gnt_d, rd_gnt;
   logic [1:0]    rvalid_vec;
   logic [DW-1:0] rdata_vec [2];

   always_comb begin
      ret_cycle   = (state_reg == RD) && (cnt_reg == CW'(1));
      arb_cycle   = reset && ((state_reg == IDLE) || ret_cycle);
      fetch_first = if_req && (starve_reg == SW'(STARVE_MAX));
      gnt_if      = arb_cycle && if_req && (!d_req || fetch_first);
      gnt_d       = arb_cycle && d_req && !gnt_if;
      rd_gnt      = gnt_if || (gnt_d && !d_we);
   end

   // Index 0 is the fetch port, index 1 the data port.
   assign rvalid_vec[0] = reset && ret_cycle && !owner_reg;
   assign rvalid_vec[1] = reset && ret_cycle && owner_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
         assign rdata_vec[gi] = rvalid_vec[gi] ? mem_rdata : '0;
      end
   endgenerate

   always_comb begin
      if_gnt    = gnt_if;
      d_gnt     = gnt_d;
      mem_en    = gnt_if || gnt_d;
      mem_we    = gnt_d && d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_if) begin
         mem_addr = if_addr;
      end else if (gnt_d) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
      if_rvalid = rvalid_vec[0];
      d_rvalid  = rvalid_vec[1];
      if_rdata  = rdata_vec[0];
      d_rdata   = rdata_vec[1];
      busy      = reset && ((state_reg == RD) || gnt_if || gnt_d);
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      owner_next  = owner_reg;
      starve_next = starve_reg;
      if (arb_cycle) begin
         state_next = IDLE;
         cnt_next   = '0;
         if (rd_gnt) begin
            state_next = RD;
            cnt_next   = CW'(MEM_LAT);
            owner_next = gnt_d;
         end
      end else if (state_reg == RD) begin
         cnt_next = cnt_reg - CW'(1);
      end
      // Starvation only counts while fetch is actually waiting.
      if (!if_req || gnt_if) begin
         starve_next = '0;
      end else if (gnt_d && (starve_reg != SW'(STARVE_MAX))) begin
         starve_next = starve_reg + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         starve_reg <= '0;
         owner_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         starve_reg <= starve_next;
         owner_reg  <= owner_next;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle latency/reset
// sequences, and randomized traffic against a cycle-number based reference model.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        if_gnt;
      logic        d_gnt;
      logic        mem_en;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        if_rvalid;
      logic [31:0] if_rdata;
      logic        d_rvalid;
      logic [31:0] d_rdata;
      logic        busy;
   } outs_t;

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      outs_t       exp;
   } vec_t;

   localparam int SMAX = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;

   logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
   logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
      .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
      .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h2002_0001;
      if (i == 1) return 32'h0000_003a;
      return 32'h5a00_0000 | 32'(i);
   endfunction

   // Memory models, reloaded during any clock edge with reset low.
   logic [31:0] mem1 [0:63];
   logic [31:0] pipe1 [0:3];
   logic [31:0] mem3 [0:63];
   logic [31:0] pipe3 [0:3];

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) mem1[i] <= init_word(i);
      end else if (mem_en1 && mem_we1) begin
         mem1[mem_addr1[7:2]] <= mem_wdata1;
      end
      pipe1[0] <= (mem_en1 && !mem_we1) ? mem1[mem_addr1[7:2]] : 32'hdead_beef;
      for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
   end
   assign mem_rdata1 = pipe1[0];

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) mem3[i] <= init_word(i);
      end else if (mem_en3 && mem_we3) begin
         mem3[mem_addr3[7:2]] <= mem_wdata3;
      end
      pipe3[0] <= (mem_en3 && !mem_we3) ? mem3[mem_addr3[7:2]] : 32'hdead_beef;
      for (int i = 1; i < 4; i++) pipe3[i] <= pipe3[i-1];
   end
   assign mem_rdata3 = pipe3[2];

   function automatic outs_t get1();
      return '{if_gnt1, d_gnt1, mem_en1, mem_we1, mem_addr1, mem_wdata1,
               if_rvalid1, if_rdata1, d_rvalid1, d_rdata1, busy1};
   endfunction

   function automatic outs_t get3();
      return '{if_gnt3, d_gnt3, mem_en3, mem_we3, mem_addr3, mem_wdata3,
               if_rvalid3, if_rdata3, d_rvalid3, d_rdata3, busy3};
   endfunction

   function automatic outs_t mk_out(input logic ig, input logic dg, input logic en,
                                    input logic we, input logic [31:0] ad,
                                    input logic [31:0] wd, input logic irv,
                                    input logic [31:0] ird, input logic drv,
                                    input logic [31:0] drd, input logic bz);
      return '{ig, dg, en, we, ad, wd, irv, ird, drv, drd, bz};
   endfunction

   function automatic vec_t mk_vec(input logic ir, input logic [31:0] ia, input logic dr,
                                   input logic dw, input logic [31:0] da,
                                   input logic [31:0] dd, input outs_t e);
      return '{ir, ia, dr, dw, da, dd, e};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // strict=0 skips the memory address/data fields when no access is expected.
   task automatic cmp_outs(input string tag, input outs_t a, input outs_t e, input bit strict);
      check({tag, ".if_gnt"}, 32'(a.if_gnt), 32'(e.if_gnt));
      check({tag, ".d_gnt"}, 32'(a.d_gnt), 32'(e.d_gnt));
      check({tag, ".mem_en"}, 32'(a.mem_en), 32'(e.mem_en));
      if (strict || e.mem_en) begin
         check({tag, ".mem_we"}, 32'(a.mem_we), 32'(e.mem_we));
         check({tag, ".mem_addr"}, a.mem_addr, e.mem_addr);
         check({tag, ".mem_wdata"}, a.mem_wdata, e.mem_wdata);
      end
      check({tag, ".if_rvalid"}, 32'(a.if_rvalid), 32'(e.if_rvalid));
      check({tag, ".if_rdata"}, a.if_rdata, e.if_rdata);
      check({tag, ".d_rvalid"}, 32'(a.d_rvalid), 32'(e.d_rvalid));
      check({tag, ".d_rdata"}, a.d_rdata, e.d_rdata);
      check({tag, ".busy"}, 32'(a.busy), 32'(e.busy));
   endtask

   task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
      if_req  = ir;
      if_addr = ia;
      d_req   = dr;
      d_we    = dw;
      d_addr  = da;
      d_wdata = dd;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // One clock of dut3 stimulus (reads only), compared strictly at the negedge.
   task automatic step3(input string tag, input logic ir, input logic dr,
                        input logic [31:0] da, input outs_t e);
      @(posedge clk); #1;
      set_in(ir, 32'h0, dr, 1'b0, da, 32'h0);
      @(negedge clk);
      cmp_outs(tag, get3(), e, 1'b1);
      $display("%s: if_gnt=%0b d_gnt=%0b if_rvalid=%0b d_rvalid=%0b busy=%0b",
               tag, if_gnt3, d_gnt3, if_rvalid3, d_rvalid3, busy3);
   endtask

   vec_t        vecs[$];
   outs_t       zero_o, busy_o, exp_o;
   logic [31:0] shadow [0:63];
   bit          m_out, m_owner, e_if, e_d, arb, rt;
   int          m_ret, m_starve, cyc;
   logic [31:0] m_data;
   bit          if_pend, d_pend, if_seen, d_seen;

   initial begin
      zero_o = '0;
      busy_o = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset with requests asserted: every output must stay low.
      reset = 1'b0;
      set_in(1, 32'h4, 1, 1, 32'h8, 32'h55);
      @(posedge clk); @(posedge clk); #1;
      cmp_outs("rst_dut1", get1(), zero_o, 1'b1);
      cmp_outs("rst_dut3", get3(), zero_o, 1'b1);
      $display("reset: busy1=%0b mem_en1=%0b busy3=%0b", busy1, mem_en1, busy3);
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      // Consecutive MEM_LAT=1 cycles starting from IDLE with starve count 0.
      vecs.push_back(mk_vec(0, 0, 0, 0, 0, 0, zero_o));
      vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mk_vec(0, 0, 0, 0, 0, 0, mk_out(0, 0, 0, 0, 0, 0, 1, 32'h2002_0001, 0, 0, 1)));
      vecs.push_back(mk_vec(1, 0, 1, 0, 32'h4, 0, mk_out(0, 1, 1, 0, 32'h4, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, mk_out(1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h3a, 1)));
      vecs.push_back(mk_vec(0, 0, 0, 0, 0, 0, mk_out(0, 0, 0, 0, 0, 0, 1, 32'h2002_0001, 0, 0, 1)));
      vecs.push_back(mk_vec(1, 0, 1, 1, 32'h8, 32'ha, mk_out(0, 1, 1, 1, 32'h8, 32'ha, 0, 0, 0, 0, 1)));
      vecs.push_back(mk_vec(1, 0, 1, 1, 32'h8, 32'ha, mk_out(0, 1, 1, 1, 32'h8, 32'ha, 0, 0, 0, 0, 1)));
      vecs.push_back(mk_vec(1, 0, 1, 1, 32'h8, 32'ha, mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mk_vec(0, 0, 1, 1, 32'h8, 32'ha, mk_out(0, 1, 1, 1, 32'h8, 32'ha, 1, 32'h2002_0001, 0, 0, 1)));
      vecs.push_back(mk_vec(0, 0, 1, 0, 32'h8, 0, mk_out(0, 1, 1, 0, 32'h8, 0, 0, 0, 0, 0, 1)));
      vecs.push_back(mk_vec(0, 0, 0, 0, 0, 0, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'ha, 1)));
      vecs.push_back(mk_vec(0, 0, 0, 0, 0, 0, zero_o));

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         set_in(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
                vecs[i].d_addr, vecs[i].d_wdata);
         @(negedge clk);
         cmp_outs($sformatf("vec%0d", i), get1(), vecs[i].exp, 1'b1);
         $display("vec %0d: if_gnt=%0b d_gnt=%0b mem_addr=%h if_rvalid=%0b d_rvalid=%0b",
                  i, if_gnt1, d_gnt1, mem_addr1, if_rvalid1, d_rvalid1);
      end

      // MEM_LAT=3: a data pulse in a non-return cycle is ignored.
      do_reset();
      step3("lat3a_t0", 1, 0, 0, mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      step3("lat3a_t1", 0, 1, 32'h4, busy_o);
      step3("lat3a_t2", 0, 0, 0, busy_o);
      step3("lat3a_t3", 0, 0, 0, mk_out(0, 0, 0, 0, 0, 0, 1, 32'h2002_0001, 0, 0, 1));
      step3("lat3a_t4", 0, 0, 0, zero_o);
      // MEM_LAT=3: a held data read waits until the return cycle.
      step3("lat3b_t0", 1, 0, 0, mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      step3("lat3b_t1", 0, 1, 32'h4, busy_o);
      step3("lat3b_t2", 0, 1, 32'h4, busy_o);
      step3("lat3b_t3", 0, 1, 32'h4, mk_out(0, 1, 1, 0, 32'h4, 0, 1, 32'h2002_0001, 0, 0, 1));
      step3("lat3b_t4", 0, 0, 0, busy_o);
      step3("lat3b_t5", 0, 0, 0, busy_o);
      step3("lat3b_t6", 0, 0, 0, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3a, 1));
      step3("lat3b_t7", 0, 0, 0, zero_o);

      // Reset pulse between clock edges right after a fetch grant.
      do_reset();
      @(posedge clk); #1;
      set_in(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmp_outs("rrd_gnt1", get1(), mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
      cmp_outs("rrd_gnt3", get3(), mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      cmp_outs("rrd_in1", get1(), zero_o, 1'b1);
      cmp_outs("rrd_in3", get3(), zero_o, 1'b1);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmp_outs($sformatf("rrd_after1_%0d", i), get1(), zero_o, 1'b1);
         cmp_outs($sformatf("rrd_after3_%0d", i), get3(), zero_o, 1'b1);
         $display("post-reset %0d: if_rvalid1=%0b if_rvalid3=%0b busy1=%0b busy3=%0b",
                  i, if_rvalid1, if_rvalid3, busy1, busy3);
      end

      // Random traffic on the MEM_LAT=1 instance.
      do_reset();
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
      m_out = 0; m_owner = 0; m_ret = 0; m_starve = 0; m_data = 0; cyc = 0;
      if_pend = 0; d_pend = 0; if_seen = 0; d_seen = 0;
      for (int n = 0; n < 800; n++) begin
         @(posedge clk); #1;
         if (if_pend && if_seen) if_pend = 0;
         if (d_pend && d_seen) d_pend = 0;
         if (!if_pend) begin
            if ($urandom_range(0, 99) < 55) begin
               if_pend = 1;
               if_addr = 32'($urandom_range(0, 15)) << 2;
            end
         end else if ($urandom_range(0, 99) < 3) begin
            if_pend = 0;
         end
         if (!d_pend) begin
            if ($urandom_range(0, 99) < 70) begin
               d_pend  = 1;
               d_we    = 1'($urandom_range(0, 1));
               d_addr  = 32'($urandom_range(0, 15)) << 2;
               d_wdata = $urandom;
            end
         end else if ($urandom_range(0, 99) < 3) begin
            d_pend = 0;
         end
         if_req = if_pend;
         d_req  = d_pend;
         @(negedge clk);

         arb  = !m_out || (cyc == m_ret);
         rt   = m_out && (cyc == m_ret);
         e_if = arb && if_req && (!d_req || m_starve >= SMAX);
         e_d  = arb && d_req && !e_if;
         exp_o           = '0;
         exp_o.if_gnt    = e_if;
         exp_o.d_gnt     = e_d;
         exp_o.mem_en    = e_if || e_d;
         exp_o.mem_we    = e_d && d_we;
         exp_o.mem_addr  = e_if ? if_addr : (e_d ? d_addr : 32'h0);
         exp_o.mem_wdata = e_d ? d_wdata : 32'h0;
         exp_o.if_rvalid = rt && !m_owner;
         exp_o.if_rdata  = (rt && !m_owner) ? m_data : 32'h0;
         exp_o.d_rvalid  = rt && m_owner;
         exp_o.d_rdata   = (rt && m_owner) ? m_data : 32'h0;
         exp_o.busy      = m_out || e_if || e_d;
         cmp_outs($sformatf("rnd%0d", n), get1(), exp_o, 1'b0);
         if (e_if || e_d)
            $display("rnd %0d: %s %s addr=%h", n, e_if ? "fetch" : "data",
                     (e_d && d_we) ? "write" : "read", e_if ? if_addr : d_addr);
         if_seen = if_gnt1;
         d_seen  = d_gnt1;

         if (rt) m_out = 0;
         if (e_if || (e_d && !d_we)) begin
            m_out   = 1;
            m_ret   = cyc + 1;
            m_owner = e_d;
            m_data  = shadow[e_if ? if_addr[7:2] : d_addr[7:2]];
         end
         if (e_d && d_we) shadow[d_addr[7:2]] = d_wdata;
         if (!if_req || e_if) m_starve = 0;
         else if (e_d && m_starve < SMAX) m_starve++;
         cyc++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
